direction_ctrl: RTL and testbench

Direction controller for the 6-bit up/down counter: it produces the counter's `direction` select and watches the count it produces. It feeds `direction` into the counter and takes the counter's `dout` back on `count`. It debounces a raw push-button, toggles direction on each debounced press, and in auto mode makes the counter ping-pong between two limits without overshoot.

---
 rtl/counter_pkg.sv | 7 +
 rtl/direction_ctrl_if.sv | 12 +
 rtl/btn_debounce.sv | 34 +++
 rtl/direction_ctrl.sv | 44 ++++
 tb/tb_direction_ctrl.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/counter_pkg.sv
// counter_pkg: shared constants and state encodings for the up/down counter and its direction controller
package counter_pkg;
  localparam int CW = 6;
  localparam logic DIR_UP = 1'b0;
  localparam logic DIR_DOWN = 1'b1;
  typedef enum logic {ST_UP = 1'b0, ST_DOWN = 1'b1} state_t;
endpackage

// File: rtl/direction_ctrl_if.sv
// direction_ctrl_if: button, mode and count-feedback bundle between the counter side and the direction controller
interface direction_ctrl_if;
  import counter_pkg::*;
  logic btn_raw;
  logic auto;
  logic [CW-1:0] count;
  logic direction;
  logic btn_pulse;
  logic at_limit;
  modport master(output btn_raw, auto, count, input direction, btn_pulse, at_limit);
  modport slave(input btn_raw, auto, count, output direction, btn_pulse, at_limit);
endinterface

// File: rtl/btn_debounce.sv
// btn_debounce: two-flop synchronizer plus counting debouncer with a one-cycle pulse on each accepted rising press
module btn_debounce #(
  parameter int DB_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic db,
  output logic btn_pulse
);
  localparam int W = $clog2(DB_CYCLES);
  localparam logic [W-1:0] DB_MAX = W'(DB_CYCLES - 1);
  logic s1, s2;
  logic [W-1:0] dbc;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      db <= 1'b0;
      dbc <= '0;
      btn_pulse <= 1'b0;
    end else begin
      s1 <= btn_raw;
      s2 <= s1;
      btn_pulse <= 1'b0;
      if (s2 == db) dbc <= '0;
      else if (dbc == DB_MAX) begin
        db <= s2;
        dbc <= '0;
        btn_pulse <= s2;
      end else dbc <= dbc + 1'b1;
    end
  end
endmodule

// File: rtl/direction_ctrl.sv
// direction_ctrl: debounced manual direction toggle and early-turning auto ping-pong between LO and HI
module direction_ctrl
  import counter_pkg::*;
#(
  parameter logic [CW-1:0] LO = 6'd0,
  parameter logic [CW-1:0] HI = 6'd63,
  parameter int DB_CYCLES = 16
) (
  input logic CLK,
  input logic reset,
  direction_ctrl_if.slave bus
);
  localparam logic [CW-1:0] HI_TURN = HI - CW'(1);
  localparam logic [CW-1:0] LO_TURN = LO + CW'(1);
  state_t state, state_nxt;
  logic pulse, lim, lim_nxt, turn_up, turn_dn;
  logic db_unused;
  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
    .clk(CLK),
    .rst_n(reset),
    .btn_raw(bus.btn_raw),
    .db(db_unused),
    .btn_pulse(pulse)
  );
  // Turning one step early because direction is registered: the counter lands exactly on the limit
  always_comb begin
    turn_dn = bus.auto && state == ST_UP && bus.count >= HI_TURN;
    turn_up = bus.auto && state == ST_DOWN && bus.count <= LO_TURN;
    lim_nxt = turn_dn || turn_up;
    state_nxt = turn_dn ? ST_DOWN : turn_up ? ST_UP : pulse ? state_t'(~state) : state;
  end
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state <= ST_UP;
      lim <= 1'b0;
    end else begin
      state <= state_nxt;
      lim <= lim_nxt;
    end
  end
  assign bus.direction = (state == ST_DOWN) ? DIR_DOWN : DIR_UP;
  assign bus.btn_pulse = pulse;
  assign bus.at_limit = lim;
endmodule

// File: tb/tb_direction_ctrl.sv
// tb_direction_ctrl: scoreboard bench for the direction controller with LO=2, HI=9, DB_CYCLES=4
module tb_direction_ctrl;
  typedef logic [2:0] exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;
  exp_t sb[$];
  logic [5:0] cq[$];
  direction_ctrl_if bus();
  direction_ctrl #(.LO(6'd2), .HI(6'd9), .DB_CYCLES(4)) dut (
    .CLK(clk),
    .reset(rst_n),
    .bus(bus)
  );
  always #5 clk = ~clk;

  function automatic exp_t obs();
    return {bus.btn_pulse, bus.direction, bus.at_limit};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.btn_raw = 1'b0;
    bus.auto = 1'b0;
    bus.count = 6'd0;
    sb.delete();
    cq.delete();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    exp_t e;
    do_reset();
    bus.btn_raw = 1'b1;
    repeat (10) tick();
    bus.btn_raw = 1'b0;
    repeat (10) tick();
    checks++;
    if (bus.direction !== 1'b1) begin
      failures++;
      $display("FAIL reset_setup direction got=%b required=1", bus.direction);
    end
    bus.btn_raw = 1'b1;
    repeat (4) tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if (obs() !== 3'b000) begin
      failures++;
      $display("FAIL reset_async {pulse,dir,lim} got=%b required=000", obs());
    end
    bus.btn_raw = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    bus.btn_raw = 1'b1;
    tick();
    tick();
    bus.btn_raw = 1'b0;
    for (int i = 0; i < 20; i++) begin
      sb.push_back(3'b000);
      tick();
      e = sb.pop_front();
      checks++;
      if (obs() !== e) begin
        failures++;
        $display("FAIL reset_after cyc=%0d got=%b required=%b", i, obs(), e);
      end
    end
  endtask

  task automatic test_press();
    exp_t e;
    do_reset();
    bus.count = 6'd30;
    bus.btn_raw = 1'b1;
    for (int n = 1; n <= 30; n++) sb.push_back({n == 6, n >= 7, 1'b0});
    for (int n = 1; n <= 30; n++) begin
      tick();
      if (n == 10) bus.btn_raw = 1'b0;
      e = sb.pop_front();
      checks++;
      if (obs() !== e) begin
        failures++;
        $display("FAIL press edge=%0d got=%b required=%b", n, obs(), e);
      end
    end
  endtask

  task automatic test_bounce();
    exp_t e;
    do_reset();
    for (int i = 0; i < 50; i++) begin
      bus.btn_raw = (i < 40) ? (((i / 2) % 2) == 0) : 1'b0;
      sb.push_back(3'b000);
      tick();
      e = sb.pop_front();
      checks++;
      if (obs() !== e) begin
        failures++;
        $display("FAIL bounce cyc=%0d got=%b required=%b", i, obs(), e);
      end
    end
  endtask

  task automatic test_auto_bounce();
    exp_t e;
    logic [5:0] c, nxt;
    int m, v;
    do_reset();
    bus.auto = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      m = (n >= 9) ? (n - 9) % 14 : 0;
      v = (n <= 9) ? n : ((m <= 7) ? 9 - m : m - 5);
      sb.push_back({1'b0, n >= 9 && m < 7, n >= 9 && (m == 0 || m == 7)});
      cq.push_back(6'(v));
      nxt = bus.direction ? bus.count - 6'd1 : bus.count + 6'd1;
      tick();
      bus.count = nxt;
      e = sb.pop_front();
      c = cq.pop_front();
      checks++;
      if (obs() !== e || bus.count !== c) begin
        failures++;
        $display("FAIL auto edge=%0d count=%0d flags=%b required count=%0d flags=%b", n, bus.count, obs(), c, e);
      end
    end
  endtask

  task automatic test_simultaneous();
    exp_t e;
    do_reset();
    bus.auto = 1'b1;
    bus.count = 6'd5;
    bus.btn_raw = 1'b1;
    for (int n = 1; n <= 14; n++) begin
      sb.push_back({n == 6, n >= 7, n == 7});
      tick();
      bus.count = (n == 6) ? 6'd8 : (n >= 7) ? 6'd7 : 6'd5;
      if (n == 9) bus.btn_raw = 1'b0;
      e = sb.pop_front();
      checks++;
      if (obs() !== e) begin
        failures++;
        $display("FAIL simultaneous edge=%0d got=%b required=%b", n, obs(), e);
      end
    end
  endtask

  task automatic test_manual_wrap();
    exp_t e;
    int n;
    logic [5:0] up_seq[4] = '{6'd62, 6'd63, 6'd0, 6'd1};
    logic [5:0] dn_seq[4] = '{6'd1, 6'd0, 6'd63, 6'd62};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      bus.count = up_seq[i];
      sb.push_back(3'b000);
      tick();
      e = sb.pop_front();
      checks++;
      if (obs() !== e) begin
        failures++;
        $display("FAIL wrap_up count=%0d got=%b required=%b", bus.count, obs(), e);
      end
    end
    bus.btn_raw = 1'b1;
    n = 0;
    while (bus.direction !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (bus.direction !== 1'b1) begin
      failures++;
      $display("FAIL wrap_press_timeout direction=%b required=1", bus.direction);
    end
    bus.btn_raw = 1'b0;
    repeat (10) tick();
    for (int i = 0; i < 4; i++) begin
      bus.count = dn_seq[i];
      sb.push_back(3'b010);
      tick();
      e = sb.pop_front();
      checks++;
      if (obs() !== e) begin
        failures++;
        $display("FAIL wrap_down count=%0d got=%b required=%b", bus.count, obs(), e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_press();
    test_bounce();
    test_auto_bounce();
    test_simultaneous();
    test_manual_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
